// File: rtl/rs232_avs_responder.sv
// ---------------------------------------------------------------------------
// rs232_avs_responder
//   Avalon-MM slave UART register model. Bytes arriving on the rx byte stream
//   are buffered in a small FIFO and read out through RXDATA. Bytes written to
//   TXDATA sit in a one-entry holding register until the tx sink takes them.
//
//   Register map (byte addresses on avs_address):
//     0  RXDATA  read: head byte of RX FIFO (pops), 0 when empty
//     4  TXDATA  write: load tx holding register; read returns 0
//     8  STATUS  bit7 RRDY (RX FIFO non-empty), bit6 TRDY (tx register empty),
//                bit3 OVERRUN (sticky, only with RS232_AVS_OVERRUN_EN)
//     other addresses: reads return 0, writes are acknowledged and ignored
//
//   Handshakes: a byte stream transfer happens on the rising clock edge where
//   valid && ready are both high. An Avalon access is accepted on the edge
//   where the master holds avs_read/avs_write and avs_waitrequest is low; the
//   read response follows exactly one cycle later on avs_readdatavalid.
//
//   Build option: define RS232_AVS_OVERRUN_EN to make rx_rdy always high
//   (outside reset); bytes that arrive while the FIFO is full are dropped and
//   flagged in STATUS bit3. Without it rx_rdy = !full and no byte is ever lost.
//
//   Ports:
//     i_clk, i_rst                   clock, asynchronous active-high reset
//     avs_address/read/write/writedata, avs_waitrequest,
//     avs_readdatavalid, avs_readdata Avalon-MM slave port
//     rx_val, rx_rdy, rx_data        incoming byte stream
//     tx_val, tx_rdy, tx_data        outgoing byte stream
//     dbg_state_o                    access FSM phase (IDLE/WAIT/ACCEPT)
// ---------------------------------------------------------------------------
module rs232_avs_responder #(
  parameter int RX_DEPTH    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic        avs_readdatavalid,
  output logic [31:0] avs_readdata,
  input  logic        rx_val,
  output logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        tx_val,
  input  logic        tx_rdy,
  output logic [7:0]  tx_data,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] ADDR_RX = 5'd0;
  localparam logic [4:0] ADDR_TX = 5'd4;
  localparam logic [4:0] ADDR_ST = 5'd8;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACCEPT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d, cnt_eff;
  logic            req, is_wr, is_rd, tx_block, cnt_done, accept;
  logic            rdv_q;
  logic [31:0]     rdata_q, rd_val;
  logic            tx_val_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      mem_q [RX_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full, empty, push, pop, ovr_flag;
  logic            unused_wdata;

  assign unused_wdata = ^avs_writedata[31:8];

  // A simultaneous read+write is handled as a write only.
  assign req      = avs_read || avs_write;
  assign is_wr    = avs_write;
  assign is_rd    = avs_read && !avs_write;
  assign tx_block = is_wr && (avs_address == ADDR_TX) && tx_val_q;

  // Wait cycles already spent on the current request; a fresh request in
  // IDLE has spent none, which lets WAIT_CYCLES=0 accept immediately.
  assign cnt_eff  = (state_q == ST_WAIT) ? cnt_q : 3'd0;
  assign cnt_done = (cnt_eff >= 3'(WAIT_CYCLES));
  assign accept   = !i_rst && req && cnt_done && !tx_block;

  // ---------------- access FSM: state register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- access FSM: next state ----------------
  // ACCEPT is the single cycle in which accept is high; it always returns to
  // IDLE, as does a request dropped mid-wait (counter cleared).
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = 3'd0;
    if (req && !accept) begin
      state_d = ST_WAIT;
      cnt_d   = cnt_done ? cnt_eff : cnt_eff + 3'd1;
    end
  end

  // ---------------- access FSM: outputs ----------------
  always_comb begin
    avs_waitrequest = !accept;
    dbg_state_o     = accept ? ST_ACCEPT : state_q;
  end

  // ---------------- RX FIFO ----------------
  assign full  = (count_q == CW'(RX_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = accept && is_rd && (avs_address == ADDR_RX) && !empty;

`ifdef RS232_AVS_OVERRUN_EN
  logic drop;
  logic ovr_q;
  assign rx_rdy   = !i_rst;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push     = rx_val && rx_rdy && (!full || pop);
  assign drop     = rx_val && rx_rdy && full && !pop;
  assign ovr_flag = ovr_q;

  // Set wins over clear so a drop coinciding with a STATUS read is not lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovr_q <= 1'b0;
    end else if (drop) begin
      ovr_q <= 1'b1;
    end else if (accept && is_rd && (avs_address == ADDR_ST)) begin
      ovr_q <= 1'b0;
    end
  end
`else
  assign rx_rdy   = !i_rst && !full;
  assign push     = rx_val && rx_rdy;
  assign ovr_flag = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- read data mux (sampled in the ACCEPT cycle) ----------------
  always_comb begin
    rd_val = 32'd0;
    case (avs_address)
      ADDR_RX: if (!empty) rd_val[7:0] = mem_q[rd_ptr_q];
      ADDR_ST: begin
        rd_val[7] = !empty;
        rd_val[6] = !tx_val_q;
        rd_val[3] = ovr_flag;
      end
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdv_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      rdv_q <= accept && is_rd;
      if (accept && is_rd) rdata_q <= rd_val;
    end
  end

  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;

  // ---------------- TX holding register ----------------
  // A TXDATA write is only accepted when the register is empty, so load and
  // drain never collide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_val_q  <= 1'b0;
      tx_data_q <= 8'd0;
    end else if (accept && is_wr && (avs_address == ADDR_TX)) begin
      tx_val_q  <= 1'b1;
      tx_data_q <= avs_writedata[7:0];
    end else if (tx_val_q && tx_rdy) begin
      tx_val_q  <= 1'b0;
    end
  end

  assign tx_val  = tx_val_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_rs232_avs_responder.sv
// ---------------------------------------------------------------------------
// tb_rs232_avs_responder
//   Directed bench for rs232_avs_responder (WAIT_CYCLES=3, RX_DEPTH=4).
//   Read responses and transmitted bytes are checked by monitors against
//   expected queues filled by the stimulus; timing and reset values are
//   checked inline. Inputs change 1 time unit after the rising edge, outputs
//   are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rs232_avs_responder;

  localparam int WC    = 3;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_waitrequest, avs_readdatavalid;
  logic [31:0] avs_readdata;
  logic        rx_val = 1'b0, rx_rdy;
  logic [7:0]  rx_data = '0;
  logic        tx_val, tx_rdy = 1'b0;
  logic [7:0]  tx_data;
  logic [1:0]  dbg_state;

  rs232_avs_responder #(.RX_DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdatavalid(avs_readdatavalid), .avs_readdata(avs_readdata),
    .rx_val(rx_val), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_data(tx_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!i_rst && avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got 0x%0h expected no response", avs_readdata);
      end else begin
        check("rd_data", avs_readdata, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!i_rst && tx_val && tx_rdy) begin
      if (tx_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic start_access(input logic [4:0] addr, input logic rd, input logic wr,
                              input logic [31:0] data);
    avs_address   = addr;
    avs_read      = rd;
    avs_write     = wr;
    avs_writedata = data;
  endtask

  task automatic wait_accept(output int waits);
    bit ok = 1'b0;
    waits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin ok = 1'b1; break; end
      waits++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp);
    int waits;
    exp_q.push_back(exp);
    start_access(addr, 1'b1, 1'b0, 32'd0);
    wait_accept(waits);
    check("rd_waits", waits, WC);
    @(negedge clk);
    check("rd_latency", {31'd0, avs_readdatavalid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    int waits;
    start_access(addr, 1'b0, 1'b1, data);
    wait_accept(waits);
    check("wr_waits", waits, WC);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_val  = 1'b1;
    rx_data = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) check("rx_push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_val = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    int lows;
    bit ok;

    // Power-on reset values.
    repeat (2) @(negedge clk);
    check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    check("rst_rdv", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_txval", {31'd0, tx_val}, 32'd0);
    check("rst_txdata", {24'd0, tx_data}, 32'd0);
    check("rst_rxrdy", {31'd0, rx_rdy}, 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted in the middle of a TXDATA write's wait phase.
    tx_rdy = 1'b0;
    start_access(5'd4, 1'b0, 1'b1, 32'h33);
    @(negedge clk);
    check("mw_wait0", {31'd0, avs_waitrequest}, 32'd1);
    @(negedge clk);
    check("mw_wait1", {31'd0, avs_waitrequest}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("mw_rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
    check("mw_rst_txval", {31'd0, tx_val}, 32'd0);
    check("mw_rst_rxrdy", {31'd0, rx_rdy}, 32'd0);
    check("mw_rst_rdv", {31'd0, avs_readdatavalid}, 32'd0);
    avs_write = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_val) lows++;
    end
    check("mw_txval_stays0", lows, 0);
    check("mw_rxrdy_after", {31'd0, rx_rdy}, 32'd1);
    @(posedge clk); #1;

    // Two bytes in, STATUS, two RXDATA reads, STATUS again (TX register empty).
    push_byte(8'h11);
    push_byte(8'h22);
    do_read(5'd8, 32'hC0);
    do_read(5'd0, 32'h11);
    do_read(5'd0, 32'h22);
    do_read(5'd8, 32'h40);

    // Empty RXDATA read, unmapped/TXDATA reads, unmapped write.
    do_read(5'd0, 32'h00);
    do_read(5'd8, 32'h40);
    do_read(5'd12, 32'h00);
    do_read(5'd4, 32'h00);
    do_write(5'd16, 32'h5);
    @(negedge clk);
    check("unmapped_wr_txval", {31'd0, tx_val}, 32'd0);
    @(posedge clk); #1;

    // Read and write together: acked as a write, no read response.
    start_access(5'd8, 1'b1, 1'b1, 32'd0);
    wait_accept(waits);
    lows = 0;
    repeat (3) begin
      @(negedge clk);
      if (avs_readdatavalid) lows++;
    end
    check("rdwr_no_rdv", lows, 0);
    @(posedge clk); #1;

    // Write request dropped mid-wait: no effect, counter restarts.
    start_access(5'd4, 1'b0, 1'b1, 32'h99);
    @(negedge clk);
    @(posedge clk); #1;
    avs_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_read(5'd8, 32'h40);
    check("drop_txval", {31'd0, tx_val}, 32'd0);

    // TX holding register: second write stalls until the first byte drains.
    tx_exp_q.push_back(8'h5A);
    tx_exp_q.push_back(8'hA5);
    do_write(5'd4, 32'h5A);
    @(negedge clk);
    check("tx_val_set", {31'd0, tx_val}, 32'd1);
    check("tx_data_5a", {24'd0, tx_data}, 32'h5A);
    @(posedge clk); #1;
    do_read(5'd8, 32'h00);
    start_access(5'd4, 1'b0, 1'b1, 32'hA5);
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (!avs_waitrequest) lows++;
    end
    check("tx_full_stall", lows, 0);
    @(posedge clk); #1;
    tx_rdy = 1'b1;
    wait_accept(waits);
    check("tx_accept_after_drain", waits, 1);
    repeat (3) @(posedge clk);
    #1;
    do_read(5'd8, 32'h40);

    // Fill the RX FIFO.
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    @(negedge clk);
`ifdef RS232_AVS_OVERRUN_EN
    check("full_rxrdy", {31'd0, rx_rdy}, 32'd1);
`else
    check("full_rxrdy", {31'd0, rx_rdy}, 32'd0);
`endif
    @(posedge clk); #1;

    // Pop the head while a new byte is offered; FIFO ends full again.
    rx_val  = 1'b1;
    rx_data = 8'hB5;
    exp_q.push_back(32'hA1);
    start_access(5'd0, 1'b1, 1'b0, 32'd0);
    wait_accept(waits);
`ifdef RS232_AVS_OVERRUN_EN
    rx_val = 1'b0;
`else
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_rdy) begin ok = 1'b1; break; end
    end
    check("pp_push_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    rx_val = 1'b0;
    @(negedge clk);
    check("pp_full_again", {31'd0, rx_rdy}, 32'd0);
    @(posedge clk); #1;
`endif
    repeat (2) @(posedge clk);
    #1;

`ifdef RS232_AVS_OVERRUN_EN
    // Overrun: TX held full so STATUS is exactly RRDY|OVERRUN, then RRDY.
    tx_rdy = 1'b0;
    tx_exp_q.push_back(8'h3C);
    do_write(5'd4, 32'h3C);
    push_byte(8'h77);
    do_read(5'd8, 32'h88);
    do_read(5'd8, 32'h80);
    tx_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif

    // Drain in order; the pushed-while-popping byte comes last.
    do_read(5'd0, 32'hA2);
    do_read(5'd0, 32'hA3);
    do_read(5'd0, 32'hA4);
    do_read(5'd0, 32'hB5);
    do_read(5'd8, 32'h40);
    do_read(5'd0, 32'h00);

    repeat (4) @(posedge clk);
    check("rd_queue_empty", exp_q.size(), 0);
    check("tx_queue_empty", tx_exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
